// File: rtl/sdram_arbiter.sv
// Three-way Call/Done arbiter in front of sdram_basemod: page read has fixed priority, user write/read round-robin.
// Optional BUSY watchdog enabled by defining ARB_TIMEOUT_EN.
module sdram_arbiter #(
   parameter int ADDR_W      = 24,
   parameter int DATA_W      = 16,
   parameter int TIMEOUT_CYC = 1023
) (
   input  logic              iClock,
   input  logic              RESET,
   input  logic [2:0]        iCall,
   output logic [2:0]        oDone,
   input  logic [ADDR_W-1:0] iAddrPage,
   input  logic [ADDR_W-1:0] iAddr,
   input  logic [DATA_W-1:0] iData,
   output logic [DATA_W-1:0] oRdData,
   output logic [2:0]        oCall,
   input  logic [2:0]        iDone,
   output logic [ADDR_W-1:0] oAddr,
   output logic [ADDR_W-1:0] oAddrPage,
   output logic [DATA_W-1:0] oData,
   input  logic [DATA_W-1:0] iRdData,
   output logic              oBusy,
   output logic              oErr
);

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_GRANT   = 2'd1;
   localparam logic [1:0] ST_RELEASE = 2'd2;

   logic [1:0]        state_reg;
   logic [2:0]        grant_reg;
   logic [2:0]        done_reg;
   logic              rr_reg;
   logic [ADDR_W-1:0] addr_reg;
   logic [ADDR_W-1:0] addr_page_reg;
   logic [DATA_W-1:0] data_reg;
   logic [DATA_W-1:0] rd_data_reg;
   logic [2:0]        win_next;
   logic              done_hit;

   // Page read beats everything; rr_reg only breaks a write/read tie (1 = write).
   always_comb begin
      win_next = 3'b000;
      if (iCall[2])
         win_next = 3'b100;
      else if (iCall[1] && iCall[0])
         win_next = rr_reg ? 3'b010 : 3'b001;
      else if (iCall[1])
         win_next = 3'b010;
      else if (iCall[0])
         win_next = 3'b001;
   end

   assign done_hit = |(iDone & grant_reg);

`ifdef ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
   localparam logic [CNT_W-1:0] TMO_LIMIT = CNT_W'(TIMEOUT_CYC);

   logic [CNT_W-1:0] cnt_reg;
   logic             err_reg;
   logic             tmo_hit;

   assign tmo_hit = (cnt_reg == TMO_LIMIT);

   always_ff @(posedge iClock or negedge RESET) begin
      if (!RESET) begin
         cnt_reg <= '0;
         err_reg <= 1'b0;
      end else begin
         err_reg <= 1'b0;
         if (state_reg == ST_IDLE)
            cnt_reg <= '0;
         else if (state_reg == ST_GRANT) begin
            // A real done in the limit cycle takes precedence over the watchdog.
            if (tmo_hit && !done_hit)
               err_reg <= 1'b1;
            cnt_reg <= cnt_reg + 1'b1;
         end
      end
   end

   assign oErr = err_reg;
`else
   logic tmo_hit;
   assign tmo_hit = 1'b0;
   assign oErr    = 1'b0;
`endif

   always_ff @(posedge iClock or negedge RESET) begin
      if (!RESET) begin
         state_reg     <= ST_IDLE;
         grant_reg     <= 3'b000;
         done_reg      <= 3'b000;
         rr_reg        <= 1'b1;
         addr_reg      <= '0;
         addr_page_reg <= '0;
         data_reg      <= '0;
         rd_data_reg   <= '0;
      end else begin
         done_reg <= 3'b000;
         case (state_reg)
            ST_IDLE: begin
               if (|win_next) begin
                  grant_reg     <= win_next;
                  addr_reg      <= iAddr;
                  addr_page_reg <= iAddrPage;
                  data_reg      <= iData;
                  state_reg     <= ST_GRANT;
               end
            end
            ST_GRANT: begin
               if (done_hit) begin
                  done_reg <= grant_reg;
                  if (grant_reg[0])
                     rd_data_reg <= iRdData;
                  if (grant_reg[1] || grant_reg[0])
                     rr_reg <= ~rr_reg;
                  state_reg <= ST_RELEASE;
               end else if (tmo_hit) begin
                  // Watchdog completion: release the requester but leave read data untouched.
                  done_reg <= grant_reg;
                  if (grant_reg[1] || grant_reg[0])
                     rr_reg <= ~rr_reg;
                  state_reg <= ST_RELEASE;
               end
            end
            ST_RELEASE: begin
               grant_reg <= 3'b000;
               state_reg <= ST_IDLE;
            end
            default: begin
               grant_reg <= 3'b000;
               state_reg <= ST_IDLE;
            end
         endcase
      end
   end

   assign oCall     = (state_reg == ST_GRANT) ? grant_reg : 3'b000;
   assign oDone     = done_reg;
   assign oBusy     = (state_reg != ST_IDLE);
   assign oAddr     = addr_reg;
   assign oAddrPage = addr_page_reg;
   assign oData     = data_reg;
   assign oRdData   = rd_data_reg;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter; the timeout step is active only when ARB_TIMEOUT_EN is defined.
module tb_sdram_arbiter;

   logic        clk;
   logic        RESET;
   logic [2:0]  iCall;
   logic [2:0]  oDone;
   logic [23:0] iAddrPage;
   logic [23:0] iAddr;
   logic [15:0] iData;
   logic [15:0] oRdData;
   logic [2:0]  oCall;
   logic [2:0]  iDone;
   logic [23:0] oAddr;
   logic [23:0] oAddrPage;
   logic [15:0] oData;
   logic [15:0] iRdData;
   logic        oBusy;
   logic        oErr;

   int checks   = 0;
   int failures = 0;

   sdram_arbiter #(.ADDR_W(24), .DATA_W(16), .TIMEOUT_CYC(8)) dut (
      .iClock(clk), .RESET(RESET), .iCall(iCall), .oDone(oDone),
      .iAddrPage(iAddrPage), .iAddr(iAddr), .iData(iData), .oRdData(oRdData),
      .oCall(oCall), .iDone(iDone), .oAddr(oAddr), .oAddrPage(oAddrPage),
      .oData(oData), .iRdData(iRdData), .oBusy(oBusy), .oErr(oErr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Bounded wait for a grant, then confirm which requester won.
   task automatic wait_grant(input string tag, input logic [2:0] g);
      int n = 0;
      while (oCall == 3'b000 && n < 20) begin
         tick();
         n++;
      end
      chk(tag, {29'd0, oCall}, {29'd0, g});
   endtask

   // Hold the grant lat cycles, return iDone, check the Done pulse and the release.
   task automatic complete(input logic [2:0] g, input int lat, input bit drop);
      for (int i = 0; i < lat; i++) begin
         chk("call_held", {29'd0, oCall}, {29'd0, g});
         tick();
      end
      iDone = g;
      tick();
      iDone = 3'b000;
      chk("done_pulse", {29'd0, oDone}, {29'd0, g});
      chk("call_drop", {29'd0, oCall}, 32'd0);
      chk("busy_release", {31'd0, oBusy}, 32'd1);
      if (drop)
         iCall = iCall & ~g;
      tick();
      chk("done_clear", {29'd0, oDone}, 32'd0);
      chk("busy_idle", {31'd0, oBusy}, 32'd0);
      $display("txn grant=%b addr=%h page=%h data=%h rd=%h", g, oAddr, oAddrPage, oData, oRdData);
   endtask

   task automatic do_reset();
      RESET = 1'b0;
      tick();
      RESET = 1'b1;
   endtask

   initial begin
      RESET = 1'b0; iCall = 3'b000; iDone = 3'b000;
      iAddrPage = '0; iAddr = '0; iData = '0; iRdData = '0;
      tick();
      tick();
      chk("rst_call", {29'd0, oCall}, 32'd0);
      chk("rst_done", {29'd0, oDone}, 32'd0);
      chk("rst_busy", {31'd0, oBusy}, 32'd0);
      chk("rst_err", {31'd0, oErr}, 32'd0);
      chk("rst_addr", {8'd0, oAddr}, 32'd0);
      chk("rst_rd", {16'd0, oRdData}, 32'd0);
      RESET = 1'b1;
      tick();

      // 1. single write, one-cycle call latency
      iCall = 3'b010; iAddr = 24'h000123; iData = 16'hBEEF;
      tick();
      chk("wr_call", {29'd0, oCall}, 32'h2);
      chk("wr_addr", {8'd0, oAddr}, 32'h000123);
      chk("wr_data", {16'd0, oData}, 32'h0000BEEF);
      chk("wr_busy", {31'd0, oBusy}, 32'd1);
      complete(3'b010, 5, 1);

      // 2. read data return and hold
      iCall = 3'b001; iRdData = 16'h5A5A;
      wait_grant("rd_grant", 3'b001);
      complete(3'b001, 3, 1);
      chk("rd_data", {16'd0, oRdData}, 32'h00005A5A);
      iRdData = 16'h1111;
      iCall = 3'b010;
      wait_grant("wr2_grant", 3'b010);
      complete(3'b010, 1, 1);
      chk("rd_hold", {16'd0, oRdData}, 32'h00005A5A);

      // 3. priority with all three requesting
      do_reset();
      iAddrPage = 24'hABCDEF; iAddr = 24'h000777; iCall = 3'b111;
      wait_grant("pri_page", 3'b100);
      iAddrPage = 24'h111111;
      tick();
      chk("pri_page_addr", {8'd0, oAddrPage}, 32'h00ABCDEF);
      complete(3'b100, 1, 1);
      wait_grant("pri_write", 3'b010);
      complete(3'b010, 1, 1);
      wait_grant("pri_read", 3'b001);
      complete(3'b001, 1, 1);

      // 4. round robin with both user calls held
      do_reset();
      iCall = 3'b011;
      for (int k = 0; k < 4; k++) begin
         wait_grant("rr_grant", (k % 2 == 0) ? 3'b010 : 3'b001);
         complete((k % 2 == 0) ? 3'b010 : 3'b001, 2, 0);
      end
      iCall = 3'b000;
      tick();

      // 5. input change, stray done, call dropped mid-grant
      iCall = 3'b010; iAddr = 24'h000456; iData = 16'h1234;
      wait_grant("mid_grant", 3'b010);
      iAddr = 24'hFFFFFF; iData = 16'h0000; iDone = 3'b001;
      tick();
      iDone = 3'b000;
      chk("stray_done", {29'd0, oDone}, 32'd0);
      chk("stray_call", {29'd0, oCall}, 32'h2);
      tick();
      chk("mid_addr", {8'd0, oAddr}, 32'h000456);
      chk("mid_data", {16'd0, oData}, 32'h00001234);
      iCall = 3'b000;
      complete(3'b010, 1, 1);

      // 6a. asynchronous reset during grant
      iCall = 3'b010;
      wait_grant("rst_grant", 3'b010);
      RESET = 1'b0;
      #1;
      chk("arst_call", {29'd0, oCall}, 32'd0);
      chk("arst_done", {29'd0, oDone}, 32'd0);
      chk("arst_busy", {31'd0, oBusy}, 32'd0);
      iCall = 3'b000;
      tick();
      RESET = 1'b1;
      tick();
      chk("arst_stay_idle", {31'd0, oBusy}, 32'd0);

      // 6b. withheld done
      iCall = 3'b001; iRdData = 16'h7777;
      wait_grant("tmo_grant", 3'b001);
`ifdef ARB_TIMEOUT_EN
      begin
         int n = 0;
         while (!oErr && n < 20) begin
            tick();
            n++;
         end
         chk("tmo_latency", n, 32'd9);
         chk("tmo_done", {29'd0, oDone}, 32'h1);
         chk("tmo_call", {29'd0, oCall}, 32'd0);
         chk("tmo_rd_kept", {16'd0, oRdData}, 32'd0);
         iCall = 3'b000;
         tick();
         chk("tmo_err_clear", {31'd0, oErr}, 32'd0);
         chk("tmo_busy_idle", {31'd0, oBusy}, 32'd0);
      end
`else
      for (int i = 0; i < 12; i++)
         tick();
      chk("no_tmo_err", {31'd0, oErr}, 32'd0);
      chk("no_tmo_call", {29'd0, oCall}, 32'h1);
      complete(3'b001, 0, 1);
      chk("late_rd", {16'd0, oRdData}, 32'h00007777);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
